// File: rtl/branch_resolve.sv
// Branch resolution for the execute stage: detects mispredicts, issues a held
// fetch redirect with a one-cycle pipeline flush, and trains a bimodal BHT.
module branch_resolve #(
    parameter int unsigned BHT_IDX_W = 4,
    parameter logic [1:0]  RESET_CTR = 2'b01
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        ex_valid_i,
    input  logic        ex_is_cond_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        do_branch_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,

    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        flush_o,

    input  logic [31:0] fetch_pc_i,
    output logic        bht_taken_o,

    output logic [31:0] stat_branch_o,
    output logic [31:0] stat_mispred_o
);

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CTR_W = 2;
    localparam int unsigned BHT_N = 2 ** BHT_IDX_W;

    logic [PC_W-1:0]      seq_pc_c;
    logic [PC_W-1:0]      actual_next_c;
    logic [PC_W-1:0]      pred_next_c;
    logic                 accept_c;
    logic                 mispredict_c;
    logic                 cond_upd_c;
    logic                 handshake_c;
    logic [BHT_IDX_W-1:0] upd_idx_c;
    logic [BHT_IDX_W-1:0] fetch_idx_c;
    logic [CTR_W-1:0]     upd_ctr_c;
    logic [CTR_W-1:0]     ctr_next_c;

    logic                 redirect_valid_d;
    logic [PC_W-1:0]      redirect_pc_d;
    logic                 flush_d;
    logic [PC_W-1:0]      stat_branch_d;
    logic [PC_W-1:0]      stat_mispred_d;

    logic [CTR_W-1:0]     bht_q [BHT_N];

    // Resolve the instruction in EX against the prediction it carried from fetch.
    always_comb begin
        seq_pc_c      = ex_pc_i + 32'd4;
        actual_next_c = do_branch_i     ? ex_target_i      : seq_pc_c;
        pred_next_c   = ex_pred_taken_i ? ex_pred_target_i : seq_pc_c;
        // EX contents behind a pending redirect are wrong-path and must not act.
        accept_c      = ex_valid_i & ~redirect_valid_o;
        mispredict_c  = accept_c & (actual_next_c != pred_next_c);
        cond_upd_c    = accept_c & ex_is_cond_i;
        handshake_c   = redirect_valid_o & redirect_ready_i;
    end

    // Saturating counter update for the resolving branch.
    always_comb begin
        upd_idx_c   = ex_pc_i[BHT_IDX_W+1:2];
        fetch_idx_c = fetch_pc_i[BHT_IDX_W+1:2];
        upd_ctr_c   = bht_q[upd_idx_c];
        ctr_next_c  = upd_ctr_c;
        if (do_branch_i) begin
            if (upd_ctr_c != 2'd3) ctr_next_c = CTR_W'(upd_ctr_c + 2'd1);
        end else begin
            if (upd_ctr_c != 2'd0) ctr_next_c = CTR_W'(upd_ctr_c - 2'd1);
        end
    end

    // Fetch sees the stored value; a same-cycle update lands at the edge.
    assign bht_taken_o = bht_q[fetch_idx_c][1];

    // Next-state for the redirect handshake, flush pulse and event counters.
    always_comb begin
        redirect_valid_d = redirect_valid_o;
        redirect_pc_d    = redirect_pc_o;
        flush_d          = 1'b0;
        stat_branch_d    = stat_branch_o;
        stat_mispred_d   = stat_mispred_o;

        if (handshake_c) begin
            redirect_valid_d = 1'b0;
        end
        // A mispredict can only be accepted while no redirect is outstanding.
        if (mispredict_c) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = actual_next_c;
            flush_d          = 1'b1;
            stat_mispred_d   = stat_mispred_o + 32'd1;
        end
        if (cond_upd_c) begin
            stat_branch_d = stat_branch_o + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_o          <= 1'b0;
            stat_branch_o    <= '0;
            stat_mispred_o   <= '0;
        end else begin
            redirect_valid_o <= redirect_valid_d;
            redirect_pc_o    <= redirect_pc_d;
            flush_o          <= flush_d;
            stat_branch_o    <= stat_branch_d;
            stat_mispred_o   <= stat_mispred_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(BHT_N); i++) begin
                bht_q[i] <= RESET_CTR;
            end
        end else if (cond_upd_c) begin
            bht_q[upd_idx_c] <= ctr_next_c;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: reference model plus a redirect-PC
// scoreboard, checked with immediate assertions after every clock edge.
module tb_branch_resolve;

    localparam int unsigned IW = 4;
    localparam int unsigned NE = 2 ** IW;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        ex_valid_i, ex_is_cond_i, do_branch_i, ex_pred_taken_i;
    logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i, fetch_pc_i;
    logic        redirect_ready_i;
    logic        redirect_valid_o, flush_o, bht_taken_o;
    logic [31:0] redirect_pc_o, stat_branch_o, stat_mispred_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

    // Reference model state
    logic        m_rv, m_fl;
    logic [31:0] m_pc, m_sb, m_sm;
    logic [1:0]  m_bht [NE];

    branch_resolve #(.BHT_IDX_W(IW), .RESET_CTR(2'b01)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .ex_valid_i       (ex_valid_i),
        .ex_is_cond_i     (ex_is_cond_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .do_branch_i      (do_branch_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_target_i (ex_pred_target_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .flush_o          (flush_o),
        .fetch_pc_i       (fetch_pc_i),
        .bht_taken_o      (bht_taken_o),
        .stat_branch_o    (stat_branch_o),
        .stat_mispred_o   (stat_mispred_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ex_valid_i       = 1'b0;
        ex_is_cond_i     = 1'b0;
        do_branch_i      = 1'b0;
        ex_pred_taken_i  = 1'b0;
        ex_pc_i          = 32'h0;
        ex_target_i      = 32'h0;
        ex_pred_target_i = 32'h0;
    endtask

    task automatic drive(input logic cond, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic taken, input logic ptaken, input logic [31:0] ptgt);
        ex_valid_i       = 1'b1;
        ex_is_cond_i     = cond;
        ex_pc_i          = pc;
        ex_target_i      = tgt;
        do_branch_i      = taken;
        ex_pred_taken_i  = ptaken;
        ex_pred_target_i = ptgt;
    endtask

    // Advance one clock: update the model from pre-edge inputs, then compare.
    task automatic tick();
        logic [31:0] seq, act, prd;
        logic        acc, mis;
        int          idx;
        if (!rstn_i) begin
            m_rv = 1'b0; m_fl = 1'b0; m_pc = '0; m_sb = '0; m_sm = '0;
            for (int i = 0; i < int'(NE); i++) m_bht[i] = 2'b01;
            exp_q.delete();
        end else begin
            seq = ex_pc_i + 32'd4;
            act = do_branch_i ? ex_target_i : seq;
            prd = ex_pred_taken_i ? ex_pred_target_i : seq;
            acc = ex_valid_i && !m_rv;
            mis = acc && (act != prd);
            idx = int'(ex_pc_i[IW+1:2]);
            if (m_rv && redirect_ready_i) m_rv = 1'b0;
            m_fl = mis;
            if (mis) begin
                m_rv = 1'b1;
                m_pc = act;
                m_sm = m_sm + 32'd1;
                exp_q.push_back(act);
            end
            if (acc && ex_is_cond_i) begin
                m_sb = m_sb + 32'd1;
                if (do_branch_i) m_bht[idx] = (m_bht[idx] == 2'd3) ? 2'd3 : m_bht[idx] + 2'd1;
                else             m_bht[idx] = (m_bht[idx] == 2'd0) ? 2'd0 : m_bht[idx] - 2'd1;
            end
        end
        @(posedge clk_i);
        #1;
        check("redirect_valid", 32'(redirect_valid_o), 32'(m_rv));
        check("redirect_pc",    redirect_pc_o, m_pc);
        check("flush",          32'(flush_o), 32'(m_fl));
        check("stat_branch",    stat_branch_o, m_sb);
        check("stat_mispred",   stat_mispred_o, m_sm);
        check("bht_taken",      32'(bht_taken_o), 32'(m_bht[int'(fetch_pc_i[IW+1:2])][1]));
        if (redirect_valid_o === 1'b1 && flush_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected observed=%h expected=none", redirect_pc_o);
            end else begin
                check("sb_redirect_pc", redirect_pc_o, exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        idle();
        tick();
        tick();
        rstn_i = 1'b1;
    endtask

    initial begin
        redirect_ready_i = 1'b1;
        fetch_pc_i       = 32'h0;
        idle();

        // Reset state
        do_reset();
        check("rst_valid", 32'(redirect_valid_o), 32'd0);
        check("rst_pc", redirect_pc_o, 32'd0);
        check("rst_bht", 32'(bht_taken_o), 32'd0);

        // Taken branch predicted not-taken
        redirect_ready_i = 1'b0;
        drive(1'b1, 32'h100, 32'h140, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        check("mp_valid", 32'(redirect_valid_o), 32'd1);
        check("mp_pc", redirect_pc_o, 32'h140);
        check("mp_flush", 32'(flush_o), 32'd1);
        check("mp_stat", stat_mispred_o, 32'd1);
        redirect_ready_i = 1'b1;
        tick();
        check("mp_done", 32'(redirect_valid_o), 32'd0);
        check("mp_flush_once", 32'(flush_o), 32'd0);

        // Redirect held under back-pressure; wrong-path EX traffic ignored
        redirect_ready_i = 1'b0;
        drive(1'b1, 32'h100, 32'h140, 1'b1, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h500 + 32'(k * 4), 32'h900, 1'b1, 1'b0, 32'h0);
            tick();
            check("hold_valid", 32'(redirect_valid_o), 32'd1);
            check("hold_pc", redirect_pc_o, 32'h140);
            check("hold_flush", 32'(flush_o), 32'd0);
        end
        idle();
        redirect_ready_i = 1'b1;
        tick();
        check("hold_release", 32'(redirect_valid_o), 32'd0);
        check("hold_stat_branch", stat_branch_o, 32'd2);
        check("hold_stat_mispred", stat_mispred_o, 32'd2);

        // Correct taken prediction trains BHT[0] from 01 to 10
        do_reset();
        fetch_pc_i = 32'h200;
        check("bht0_before", 32'(bht_taken_o), 32'd0);
        drive(1'b1, 32'h200, 32'h180, 1'b1, 1'b1, 32'h180);
        tick();
        idle();
        check("ok_no_redirect", 32'(redirect_valid_o), 32'd0);
        check("ok_stat_branch", stat_branch_o, 32'd1);
        check("bht0_after", 32'(bht_taken_o), 32'd1);

        // Predicted-taken non-branch redirects to the sequential PC
        drive(1'b0, 32'h300, 32'h0, 1'b0, 1'b1, 32'h400);
        tick();
        idle();
        check("nb_pc", redirect_pc_o, 32'h304);
        check("nb_stat_branch", stat_branch_o, 32'd1);
        check("nb_bht", 32'(bht_taken_o), 32'd1);
        tick();

        // Saturation on entry 4 in both directions
        fetch_pc_i = 32'h10;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h10, 32'h80, 1'b1, 1'b1, 32'h80);
            tick();
        end
        check("sat_hi", 32'(dut.bht_q[4]), 32'd3);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h10, 32'h80, 1'b0, 1'b0, 32'h0);
            tick();
        end
        check("sat_lo", 32'(dut.bht_q[4]), 32'd0);
        check("sat_lo_taken", 32'(bht_taken_o), 32'd0);

        // Wrong-path training attempts while a redirect is pending
        redirect_ready_i = 1'b0;
        drive(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h60);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h10, 32'h80, 1'b1, 1'b0, 32'h0);
            tick();
        end
        check("wp_bht", 32'(bht_taken_o), 32'd0);
        check("wp_stat_branch", stat_branch_o, 32'd11);

        // Reset while the redirect is still pending
        rstn_i = 1'b0;
        idle();
        tick();
        check("rr_valid", 32'(redirect_valid_o), 32'd0);
        check("rr_branch", stat_branch_o, 32'd0);
        check("rr_mispred", stat_mispred_o, 32'd0);
        for (int e = 0; e < int'(NE); e++) begin
            fetch_pc_i = 32'(e * 4);
            #1;
            check("rr_bht", 32'(bht_taken_o), 32'd0);
        end
        rstn_i = 1'b1;
        redirect_ready_i = 1'b1;
        tick();
        tick();
        check("rr_no_flush", 32'(flush_o), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
